// File: rtl/eth_rx.sv
// eth_rx: GMII receive path for a single-clock Ethernet/IPv4/UDP/ARP endpoint.
// Parses preamble/Ethernet/IPv4/UDP headers, packs the UDP payload big-endian into a
// 32-bit AXI-Stream through a small FIFO, checks the FCS and decodes ARP frames.
// Optional build macro: SRC_FILTER_EN also filters on source MAC (mac_s_addr) and
// source IP (ip_s_addr); without it those inputs are ignored.
module eth_rx #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        gmii_rx_clk,
  input  logic        gmii_rstn,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [47:0] mac_d_addr,
  input  logic [31:0] ip_d_addr,
  input  logic [47:0] mac_s_addr,
  input  logic [31:0] ip_s_addr,
  input  logic [15:0] port_s,
  input  logic [15:0] port_d,
  output logic [47:0] rq_mac_s_addr,
  output logic        arp_oper,
  output logic        arp_data_valid,
  output logic        crc_valid,
  output logic        crc_error,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  typedef enum logic [3:0] {
    StIdle, StPreamble, StEthHdr, StIpHdr, StUdpHdr, StPayload, StArp, StTail, StDrop
  } state_e;

  state_e      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [39:0] r_shift;
  logic [47:0] w_word48;
  logic [31:0] w_word32;
  logic [15:0] w_word16;
  logic        w_sfd, w_pay_byte, w_pay_cut, w_frame_end, w_clean_end, w_good;
  logic [31:0] r_crc;
  logic        r_in_frame, r_er;
  logic        r_arp_ok;
  logic [15:0] r_oper;
  logic [47:0] r_sha;
  logic [15:0] r_len;
  logic [1:0]  r_bpos;
  logic [31:0] r_word;
  logic        r_wr_en, r_wr_last;
  logic [32:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        w_empty, w_full, w_pop;
  logic [32:0] w_head;

`ifndef SRC_FILTER_EN
  logic w_unused_src;
  assign w_unused_src = ^{mac_s_addr, ip_s_addr};
`endif

  // Big-endian header fields ending at the current byte
  assign w_word48 = {r_shift, gmii_rxd};
  assign w_word32 = w_word48[31:0];
  assign w_word16 = w_word48[15:0];

  // One byte of the reflected CRC-32, LSB first, no final inversion
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  // State register, per-state byte counter and header shift register
  always_ff @(posedge gmii_rx_clk or negedge gmii_rstn) begin
    if (!gmii_rstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      r_shift <= {r_shift[31:0], gmii_rxd};
      if (w_next != r_state) r_cnt <= '0;
      else if (gmii_rx_dv && r_cnt != 5'h1F) r_cnt <= r_cnt + 5'd1;
    end
  end

  // Next-state decode; header fields are checked on the byte that completes them
  always_comb begin
    w_next = r_state;
    if (!gmii_rx_dv) begin
      w_next = StIdle;
    end else begin
      case (r_state)
        StIdle: if (gmii_rxd == 8'h55) w_next = StPreamble;
        StPreamble: begin
          if (gmii_rxd == 8'hD5) w_next = StEthHdr;
          else if (gmii_rxd != 8'h55) w_next = StDrop;
        end
        StEthHdr: begin
          if (r_cnt == 5'd5 && w_word48 != mac_d_addr && w_word48 != 48'hFFFF_FFFF_FFFF)
            w_next = StDrop;
`ifdef SRC_FILTER_EN
          if (r_cnt == 5'd11 && w_word48 != mac_s_addr) w_next = StDrop;
`endif
          if (r_cnt == 5'd13) begin
            if (w_word16 == 16'h0800) w_next = StIpHdr;
            else if (w_word16 == 16'h0806) w_next = StArp;
            else w_next = StDrop;
          end
        end
        StIpHdr: begin
          if (r_cnt == 5'd0 && gmii_rxd != 8'h45) w_next = StDrop;
          if (r_cnt == 5'd9 && gmii_rxd != 8'h11) w_next = StDrop;
`ifdef SRC_FILTER_EN
          if (r_cnt == 5'd15 && w_word32 != ip_s_addr) w_next = StDrop;
`endif
          if (r_cnt == 5'd19) w_next = (w_word32 == ip_d_addr) ? StUdpHdr : StDrop;
        end
        StUdpHdr: begin
          if (r_cnt == 5'd1 && port_s != 16'h0 && w_word16 != port_s) w_next = StDrop;
          if (r_cnt == 5'd3 && w_word16 != port_d) w_next = StDrop;
          if (r_cnt == 5'd5 && w_word16 < 16'd9) w_next = StDrop;
          if (r_cnt == 5'd7) w_next = StPayload;
        end
        StPayload: if (r_len == 16'd1) w_next = StTail;
        StArp:     if (r_cnt == 5'd27) w_next = StTail;
        StTail:    w_next = StTail;
        StDrop:    w_next = StDrop;
        default:   w_next = StIdle;
      endcase
    end
  end

  // FSM-decoded strobes
  always_comb begin
    w_sfd       = (r_state == StPreamble) && gmii_rx_dv && (gmii_rxd == 8'hD5);
    w_pay_byte  = (r_state == StPayload) && gmii_rx_dv;
    w_pay_cut   = (r_state == StPayload) && !gmii_rx_dv;
    w_frame_end = r_in_frame && !gmii_rx_dv;
    // A frame cut short inside a header or the payload is always an error
    w_clean_end = (r_state == StTail) || (r_state == StDrop);
    w_good      = w_clean_end && !r_er && (r_crc == CrcResidue);
  end

  // CRC accumulation from the SFD on, verdict pulse when dv falls
  always_ff @(posedge gmii_rx_clk or negedge gmii_rstn) begin
    if (!gmii_rstn) begin
      r_crc      <= '1;
      r_in_frame <= 1'b0;
      r_er       <= 1'b0;
      crc_valid  <= 1'b0;
      crc_error  <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      crc_error <= 1'b0;
      if (w_sfd) begin
        r_crc      <= '1;
        r_in_frame <= 1'b1;
        r_er       <= 1'b0;
      end else if (r_in_frame) begin
        if (gmii_rx_dv) begin
          r_crc <= crc_byte(r_crc, gmii_rxd);
          if (gmii_rx_er) r_er <= 1'b1;
        end else begin
          r_in_frame <= 1'b0;
          crc_valid  <= w_good;
          crc_error  <= !w_good;
        end
      end
    end
  end

  // ARP field capture; outputs commit together with a good FCS verdict
  always_ff @(posedge gmii_rx_clk or negedge gmii_rstn) begin
    if (!gmii_rstn) begin
      r_arp_ok       <= 1'b0;
      r_oper         <= '0;
      r_sha          <= '0;
      rq_mac_s_addr  <= '0;
      arp_oper       <= 1'b0;
      arp_data_valid <= 1'b0;
    end else begin
      arp_data_valid <= 1'b0;
      if (w_sfd) r_arp_ok <= 1'b0;
      if (r_state == StArp && gmii_rx_dv) begin
        if (r_cnt == 5'd7)  r_oper <= w_word16;
        if (r_cnt == 5'd13) r_sha  <= w_word48;
        if (r_cnt == 5'd27)
          r_arp_ok <= (w_word32 == ip_d_addr) && (r_oper == 16'd1 || r_oper == 16'd2);
      end
      if (w_frame_end && w_good && r_arp_ok) begin
        rq_mac_s_addr  <= r_sha;
        arp_oper       <= (r_oper == 16'd1);
        arp_data_valid <= 1'b1;
      end
    end
  end

  // Payload packing; a word is queued for the FIFO the cycle after its last byte
  always_ff @(posedge gmii_rx_clk or negedge gmii_rstn) begin
    if (!gmii_rstn) begin
      r_len     <= '0;
      r_bpos    <= '0;
      r_word    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_last <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_wr_last <= 1'b0;
      if (r_state == StUdpHdr && gmii_rx_dv && r_cnt == 5'd5) r_len <= w_word16 - 16'd8;
      if (w_pay_byte) begin
        case (r_bpos)
          2'd0:    r_word        <= {gmii_rxd, 24'h0};
          2'd1:    r_word[23:16] <= gmii_rxd;
          2'd2:    r_word[15:8]  <= gmii_rxd;
          default: r_word[7:0]   <= gmii_rxd;
        endcase
        r_len     <= r_len - 16'd1;
        r_bpos    <= (r_len == 16'd1) ? 2'd0 : r_bpos + 2'd1;
        r_wr_en   <= (r_bpos == 2'd3) || (r_len == 16'd1);
        r_wr_last <= (r_len == 16'd1);
      end else if (w_pay_cut) begin
        // Truncated payload: flush the partial word as the last one
        r_bpos    <= '0;
        r_wr_en   <= (r_bpos != 2'd0);
        r_wr_last <= (r_bpos != 2'd0);
      end else if (r_state != StPayload) begin
        r_bpos <= '0;
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = m_axis_tvalid && m_axis_tready;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // FIFO storage; writes while full are discarded, the GMII side never stalls
  always_ff @(posedge gmii_rx_clk) begin
    if (r_wr_en && !w_full) r_mem[r_wptr[AW-1:0]] <= {r_wr_last, r_word};
  end

  // FIFO pointers
  always_ff @(posedge gmii_rx_clk or negedge gmii_rstn) begin
    if (!gmii_rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (r_wr_en && !w_full) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? 32'h0 : w_head[31:0];
  assign m_axis_tlast  = !w_empty && w_head[32];

endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: directed, table-driven bench for eth_rx.
module tb_eth_rx;

  localparam logic [47:0] MacLocal  = 48'hAABB_CCDD_EEFF;
  localparam logic [31:0] IpLocal   = 32'hC0A8_0101;
  localparam logic [47:0] MacPeer   = 48'h0200_0000_0001;
  localparam logic [31:0] IpPeer    = 32'hC0A8_0164;
  localparam logic [15:0] PortLocal = 16'h138D;
  localparam logic [15:0] PortPeer  = 16'h1000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [15:0] port_s;
  logic [47:0] rq_mac_s_addr;
  logic        arp_oper, arp_data_valid, crc_valid, crc_error;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;

  always #4 clk = ~clk;

  eth_rx dut (
    .gmii_rx_clk   (clk),
    .gmii_rstn     (rstn),
    .gmii_rxd      (gmii_rxd),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .mac_d_addr    (MacLocal),
    .ip_d_addr     (IpLocal),
    .mac_s_addr    (MacPeer),
    .ip_s_addr     (IpPeer),
    .port_s        (port_s),
    .port_d        (PortLocal),
    .rq_mac_s_addr (rq_mac_s_addr),
    .arp_oper      (arp_oper),
    .arp_data_valid(arp_data_valid),
    .crc_valid     (crc_valid),
    .crc_error     (crc_error),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  frm[$];
  logic [7:0]  pay[$];
  logic [32:0] rx_q[$];
  int n_ok = 0;
  int n_err = 0;
  int n_arp = 0;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) rx_q.push_back({m_axis_tlast, m_axis_tdata});
    if (crc_valid) n_ok++;
    if (crc_error) n_err++;
    if (arp_data_valid) n_arp++;
  end

  typedef struct {
    bit          arp;
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [15:0] cfg_sport;
    int          plen;
    bit          flip;
    bit          er_last;
    logic [15:0] oper;
    logic [47:0] sha;
    int          exp_words;
    int          exp_ok;
    int          exp_err;
    int          exp_arp;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input bit arp, input logic [47:0] dmac, input logic [31:0] dip,
                         input logic [15:0] dport, input logic [15:0] cfg_sport, input int plen,
                         input bit flip, input bit er_last, input logic [15:0] oper,
                         input logic [47:0] sha, input int exp_words, input int exp_ok,
                         input int exp_err, input int exp_arp);
    vec_t v;
    v.arp = arp; v.dmac = dmac; v.dip = dip; v.dport = dport; v.cfg_sport = cfg_sport;
    v.plen = plen; v.flip = flip; v.er_last = er_last; v.oper = oper; v.sha = sha;
    v.exp_words = exp_words; v.exp_ok = exp_ok; v.exp_err = exp_err; v.exp_arp = exp_arp;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
    return r;
  endfunction

  task automatic push16(input logic [15:0] v);
    frm.push_back(v[15:8]);
    frm.push_back(v[7:0]);
  endtask

  task automatic push32(input logic [31:0] v);
    for (int i = 3; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic push48(input logic [47:0] v);
    for (int i = 5; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic pad_fcs();
    logic [31:0] c;
    while (frm.size() < 60) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < frm.size(); i++) c = crc_byte(c, frm[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic gen_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic build_udp(input logic [47:0] dmac, input logic [31:0] dip,
                           input logic [15:0] dport, input int plen);
    frm.delete();
    push48(dmac); push48(MacPeer); push16(16'h0800);
    push16(16'h4500); push16(16'(28 + plen)); push32(32'h0000_4000);
    push16(16'h4011); push16(16'h0000); push32(IpPeer); push32(dip);
    push16(PortPeer); push16(dport); push16(16'(8 + plen)); push16(16'h0000);
    for (int i = 0; i < plen; i++) frm.push_back(pay[i]);
    pad_fcs();
  endtask

  task automatic build_arp(input logic [47:0] sha, input logic [15:0] oper,
                           input logic [31:0] tip);
    frm.delete();
    push48(48'hFFFF_FFFF_FFFF); push48(sha); push16(16'h0806);
    push16(16'h0001); push16(16'h0800); push16(16'h0604); push16(oper);
    push48(sha); push32(IpPeer); push48(48'h0); push32(tip);
    pad_fcs();
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    @(posedge clk);
    #1;
    gmii_rxd = d; gmii_rx_dv = v; gmii_rx_er = e;
  endtask

  task automatic send(input int nbytes, input bit er_last);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < nbytes; i++) drive(frm[i], 1'b1, er_last && (i == nbytes - 1));
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1;
    m_axis_tready = r;
  endtask

  // Reference packing of the payload queue: big-endian, zero-padded tail
  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) if (4 * i + k < pay.size()) w[31-8*k -: 8] = pay[4*i+k];
    return w;
  endfunction

  task automatic check_words(input string tag, input int base, input int nexp, input int nlast);
    int got, bad_d, bad_l;
    got = rx_q.size() - base;
    check({tag, " word count"}, got, nexp);
    bad_d = 0;
    bad_l = 0;
    for (int i = 0; i < nexp && i < got; i++) begin
      if (rx_q[base+i][31:0] !== exp_word(i)) bad_d++;
      if (rx_q[base+i][32] !== (i == nlast)) bad_l++;
    end
    if (nexp > 0) begin
      check({tag, " bad data words"}, bad_d, 0);
      check({tag, " bad tlast flags"}, bad_l, 0);
    end
  endtask

  initial begin
    int base, b_ok, b_err, b_arp, changes;
    logic [47:0] exp_mac;
    logic        exp_oper;
    string       tag;

    rstn = 1'b0; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
    port_s = 16'h0; m_axis_tready = 1'b1;
    exp_mac = '0; exp_oper = 1'b0;

    // arp dmac dip dport port_s plen flip er oper sha | words ok err arp
    add_vec(0, MacLocal, IpLocal, PortLocal, 16'h0, 64, 0, 0, 0, 0, 16, 1, 0, 0);
    add_vec(0, MacLocal, IpLocal, PortLocal, 16'h0, 64, 1, 0, 0, 0, 16, 0, 1, 0);
    add_vec(0, MacLocal, IpLocal, PortLocal, 16'h0, 20, 0, 1, 0, 0, 5, 0, 1, 0);
    add_vec(0, 48'h0011_2233_4455, IpLocal, PortLocal, 16'h0, 16, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec(0, MacLocal, IpLocal, 16'h1234, 16'h0, 16, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 48'hFFFF_FFFF_FFFF, IpLocal, PortLocal, 16'h0, 5, 0, 0, 0, 0, 2, 1, 0, 0);
    add_vec(0, MacLocal, 32'hC0A8_0102, PortLocal, 16'h0, 16, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec(0, MacLocal, IpLocal, PortLocal, 16'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec(0, MacLocal, IpLocal, PortLocal, 16'h4321, 16, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec(0, MacLocal, IpLocal, PortLocal, 16'h1000, 9, 0, 0, 0, 0, 3, 1, 0, 0);
    add_vec(1, 0, IpLocal, 0, 16'h0, 0, 0, 0, 16'd1, 48'h1122_3344_5566, 0, 1, 0, 1);
    add_vec(1, 0, 32'hC0A8_0102, 0, 16'h0, 0, 0, 0, 16'd2, 48'h0A0B_0C0D_0E0F, 0, 1, 0, 0);
    add_vec(1, 0, IpLocal, 0, 16'h0, 0, 0, 0, 16'd2, 48'h0A0B_0C0D_0E0F, 0, 1, 0, 1);
    add_vec(1, 0, IpLocal, 0, 16'h0, 0, 0, 0, 16'd3, 48'h2222_2222_2222, 0, 1, 0, 0);
    add_vec(1, 0, IpLocal, 0, 16'h0, 0, 1, 0, 16'd1, 48'h3333_3333_3333, 0, 0, 1, 0);

    // Reset state
    idle(3);
    @(negedge clk);
    check("reset tvalid", m_axis_tvalid, 0);
    check("reset tdata", m_axis_tdata, 0);
    check("reset tlast", m_axis_tlast, 0);
    check("reset crc_valid", crc_valid, 0);
    check("reset crc_error", crc_error, 0);
    check("reset arp_data_valid", arp_data_valid, 0);
    check("reset rq_mac_s_addr", rq_mac_s_addr, 0);
    check("reset arp_oper", arp_oper, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(4);

    // Table of single-frame scenarios
    for (int vi = 0; vi < vq.size(); vi++) begin
      vec_t v;
      v = vq[vi];
      tag = $sformatf("vec%0d", vi);
      base = rx_q.size(); b_ok = n_ok; b_err = n_err; b_arp = n_arp;
      port_s = v.cfg_sport;
      if (v.arp) begin
        build_arp(v.sha, v.oper, v.dip);
        if (v.flip) frm[50] = frm[50] ^ 8'h01;
      end else begin
        gen_pay(v.plen);
        build_udp(v.dmac, v.dip, v.dport, v.plen);
        if (v.flip) begin
          frm[45] = frm[45] ^ 8'h01;
          pay[3] = pay[3] ^ 8'h01;
        end
      end
      send(frm.size(), v.er_last);
      idle(20);
      check_words(tag, base, v.exp_words, v.exp_words - 1);
      check({tag, " crc_valid pulses"}, n_ok - b_ok, v.exp_ok);
      check({tag, " crc_error pulses"}, n_err - b_err, v.exp_err);
      check({tag, " arp_data_valid pulses"}, n_arp - b_arp, v.exp_arp);
      if (v.exp_arp != 0) begin
        exp_mac = v.sha;
        exp_oper = (v.oper == 16'd1);
      end
      check({tag, " rq_mac_s_addr"}, rq_mac_s_addr, exp_mac);
      check({tag, " arp_oper"}, arp_oper, exp_oper);
      port_s = 16'h0;
    end

    // Aborted preamble: never reaches the SFD, so no FCS verdict
    b_ok = n_ok; b_err = n_err;
    drive(8'h55, 1'b1, 1'b0); drive(8'h55, 1'b1, 1'b0); drive(8'hAA, 1'b1, 1'b0);
    drive(8'h12, 1'b1, 1'b0); drive(8'h00, 1'b0, 1'b0);
    idle(10);
    check("bad preamble crc pulses", (n_ok - b_ok) + (n_err - b_err), 0);

    // dv falls after 6 payload bytes: partial word flushed with tlast
    base = rx_q.size(); b_ok = n_ok; b_err = n_err;
    gen_pay(64);
    build_udp(MacLocal, IpLocal, PortLocal, 64);
    send(48, 1'b0);
    idle(20);
    pay = pay[0:5];
    check_words("truncated", base, 2, 1);
    check("truncated crc_error", n_err - b_err, 1);
    check("truncated crc_valid", n_ok - b_ok, 0);

    // 13-byte payload held back by tready=0
    base = rx_q.size();
    set_ready(1'b0);
    gen_pay(13);
    build_udp(MacLocal, IpLocal, PortLocal, 13);
    send(frm.size(), 1'b0);
    idle(10);
    @(negedge clk);
    check("hold tvalid", m_axis_tvalid, 1);
    check("hold tdata", m_axis_tdata, exp_word(0));
    check("hold tlast", m_axis_tlast, 0);
    changes = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_axis_tdata !== exp_word(0) || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0)
        changes++;
    end
    check("hold stable cycles changed", changes, 0);
    set_ready(1'b1);
    idle(10);
    check_words("hold", base, 4, 3);

    // FIFO overflow: 20 words into a 16-deep FIFO, the tail (incl. tlast) is lost
    base = rx_q.size(); b_ok = n_ok;
    set_ready(1'b0);
    gen_pay(80);
    build_udp(MacLocal, IpLocal, PortLocal, 80);
    send(frm.size(), 1'b0);
    idle(10);
    set_ready(1'b1);
    idle(30);
    check_words("overflow", base, 16, -1);
    check("overflow crc_valid", n_ok - b_ok, 1);

    // 50 back-to-back 1024-byte frames at full rate
    b_ok = n_ok; b_err = n_err;
    for (int f = 0; f < 50; f++) begin
      base = rx_q.size();
      gen_pay(1024);
      build_udp(MacLocal, IpLocal, PortLocal, 1024);
      send(frm.size(), 1'b0);
      idle(12);
      check_words($sformatf("b2b frame %0d", f), base, 256, 255);
    end
    check("b2b crc_valid pulses", n_ok - b_ok, 50);
    check("b2b crc_error pulses", n_err - b_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
